bus_arbiter: RTL

//  Round-robin arbiter that shares one Multiplexer-driven datapath bus among numInputs requesters.

---
 rtl/arbiter_pkg.sv | 15 +
 rtl/round_robin_picker.sv | 39 +++
 rtl/bus_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package arbiter_pkg;

   typedef enum logic {
      STATE_IDLE    = 1'b0,
      STATE_GRANTED = 1'b1
   } state_t;

   // One bit of onehot(idx): returns 1 when bit position pos is the index idx.
   // Callers build a one-hot vector of any width by looping over pos.
   function automatic logic onehot_bit(input int idx, input int pos);
      return (idx == pos);
   endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin picker: scans the unmasked request bits starting at
// i_pointer, wrapping modulo numInputs, and reports the first set bit.
module round_robin_picker
   import arbiter_pkg::*;
#(
   parameter int numInputs   = 4,
   parameter int selectLines = 2
) (
   input  logic [numInputs-1:0]   i_request,
   input  logic [selectLines-1:0] i_pointer,
   input  logic [numInputs-1:0]   i_mask,
   output logic                   o_found,
   output logic [selectLines-1:0] o_winner
);

   logic [numInputs-1:0] w_eligible;
   int                   w_idx;

   assign w_eligible = i_request & ~i_mask;

   // First eligible requester at or after the pointer wins.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      o_found  = 1'b0;
      o_winner = '0;
      w_idx    = 0;
      for (int k = 0; k < numInputs; k++) begin
         w_idx = int'(i_pointer) + k;
         if (w_idx >= numInputs) begin
            w_idx = w_idx - numInputs;
         end
         if (!o_found && w_eligible[w_idx]) begin
            o_found  = 1'b1;
            o_winner = selectLines'(w_idx);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter owning the select lines of a shared bus multiplexer.
// Grants are held until the owner signals done, drops its request, or the
// hold limit forces a release; all outputs are registered.
module bus_arbiter
   import arbiter_pkg::*;
#(
   parameter int numInputs   = 4,
   parameter int selectLines = 2,
   parameter int maxHold     = 8,
   parameter int holdWidth   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [numInputs-1:0]   request,
   input  logic [numInputs-1:0]   done,
   output logic [numInputs-1:0]   grant,
   output logic [selectLines-1:0] select,
   output logic                   busy,
   output logic                   timeout
);

   localparam logic [holdWidth-1:0]   HOLD_LAST = holdWidth'(maxHold - 1);
   localparam logic [selectLines-1:0] LAST_IDX  = selectLines'(numInputs - 1);

   state_t                 r_state;
   logic [numInputs-1:0]   r_grant;
   logic [selectLines-1:0] r_select;
   logic                   r_busy;
   logic                   r_timeout;
   logic [selectLines-1:0] r_pointer;
   logic [holdWidth-1:0]   r_hold;

   state_t                 w_state_n;
   logic [numInputs-1:0]   w_grant_n;
   logic [selectLines-1:0] w_select_n;
   logic                   w_busy_n;
   logic                   w_timeout_n;
   logic [selectLines-1:0] w_pointer_n;
   logic [holdWidth-1:0]   w_hold_n;

   logic                   w_granted;
   logic                   w_owner_done;
   logic                   w_owner_req;
   logic                   w_at_limit;
   logic                   w_release;
   logic                   w_forced;
   logic [selectLines-1:0] w_ptr_after;
   logic [selectLines-1:0] w_pick_ptr;
   logic [numInputs-1:0]   w_pick_mask;
   logic [numInputs-1:0]   w_owner_onehot;
   logic [numInputs-1:0]   w_win_onehot;
   logic                   w_found;
   logic [selectLines-1:0] w_winner;

   // The owner index is always r_select while granted.
   assign w_granted    = (r_state == STATE_GRANTED);
   assign w_owner_done = done[r_select];
   assign w_owner_req  = request[r_select];
   assign w_at_limit   = (r_hold == HOLD_LAST);
   assign w_release    = w_granted && (w_owner_done || !w_owner_req || w_at_limit);
   // A limit release that coincides with done or a dropped request is a normal release.
   assign w_forced     = w_release && w_at_limit && w_owner_done == 1'b0 && w_owner_req;
   assign w_ptr_after  = (r_select == LAST_IDX) ? '0 : r_select + 1'b1;

   // On release the scan restarts after the owner with the owner masked out.
   assign w_pick_ptr  = w_granted ? w_ptr_after : r_pointer;
   assign w_pick_mask = w_granted ? w_owner_onehot : '0;

   // Expand owner and winner indices into one-hot vectors.
   always_comb begin
      w_owner_onehot = '0;
      w_win_onehot   = '0;
      for (int i = 0; i < numInputs; i++) begin
         w_owner_onehot[i] = onehot_bit(int'(r_select), i);
         w_win_onehot[i]   = onehot_bit(int'(w_winner), i);
      end
   end

   round_robin_picker #(
      .numInputs   (numInputs),
      .selectLines (selectLines)
   ) u_picker (
      .i_request (request),
      .i_pointer (w_pick_ptr),
      .i_mask    (w_pick_mask),
      .o_found   (w_found),
      .o_winner  (w_winner)
   );

   // State register and all output/datapath registers; rst wins over everything.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state   <= STATE_IDLE;
         r_grant   <= '0;
         r_select  <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_pointer <= '0;
         r_hold    <= '0;
      end else begin
         r_state   <= w_state_n;
         r_grant   <= w_grant_n;
         r_select  <= w_select_n;
         r_busy    <= w_busy_n;
         r_timeout <= w_timeout_n;
         r_pointer <= w_pointer_n;
         r_hold    <= w_hold_n;
      end
   end

   // Next-state logic: leave IDLE on any winner, return when a release finds no successor.
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         STATE_IDLE:    if (w_found) w_state_n = STATE_GRANTED;
         STATE_GRANTED: if (w_release && !w_found) w_state_n = STATE_IDLE;
         default:       w_state_n = STATE_IDLE;
      endcase
   end

   // Next output values: grant/handover/release, hold counting and the timeout pulse.
   always_comb begin
      w_grant_n   = r_grant;
      w_select_n  = r_select;
      w_busy_n    = r_busy;
      w_timeout_n = 1'b0;
      w_pointer_n = r_pointer;
      w_hold_n    = r_hold;
      if (!w_granted) begin
         if (w_found) begin
            w_grant_n  = w_win_onehot;
            w_select_n = w_winner;
            w_busy_n   = 1'b1;
            w_hold_n   = '0;
         end
      end else if (w_release) begin
         w_pointer_n = w_ptr_after;
         w_timeout_n = w_forced;
         w_hold_n    = '0;
         if (w_found) begin
            w_grant_n  = w_win_onehot;
            w_select_n = w_winner;
         end else begin
            // select is left alone so the mux output stays stable while idle.
            w_grant_n = '0;
            w_busy_n  = 1'b0;
         end
      end else begin
         w_hold_n = r_hold + 1'b1;
      end
   end

   assign grant   = r_grant;
   assign select  = r_select;
   assign busy    = r_busy;
   assign timeout = r_timeout;

endmodule
